// File: rtl/gate_truth_table_checker.sv
// Exhaustive sweep checker for a small combinational gate: drives every input
// vector, lets it settle, samples the gate output and scores it against a truth table.
module gate_truth_table_checker #(
  parameter int                 N_IN          = 2,
  parameter logic [2**N_IN-1:0] TRUTH_TABLE   = 4'b0001,
  parameter int                 SETTLE_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            dut_out,
  output logic [N_IN-1:0] dut_in,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_fail_vec,
  output logic            first_fail_valid
);

  localparam int              CW       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0]   CNT_LOAD = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1'b1);
  localparam logic [N_IN-1:0] VEC_ZERO = {N_IN{1'b0}};
  localparam logic [N_IN-1:0] VEC_ONE  = N_IN'(1'b1);
  localparam logic [N_IN-1:0] VEC_LAST = {N_IN{1'b1}};
  localparam logic [N_IN:0]   ERR_ZERO = {(N_IN + 1){1'b0}};
  localparam logic [N_IN:0]   ERR_ONE  = (N_IN + 1)'(1'b1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_CHECK  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  logic [1:0]      state_r;
  logic [CW-1:0]   cnt_r;
  logic [N_IN-1:0] dut_in_r;
  logic            busy_r;
  logic            done_r;
  logic            pass_r;
  logic [N_IN:0]   err_count_r;
  logic [N_IN-1:0] first_fail_vec_r;
  logic            first_fail_valid_r;

  // Sweep sequencer and scoreboard; the settle counter counts down from SETTLE_CYCLES-1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r            <= ST_IDLE;
      cnt_r              <= CNT_ZERO;
      dut_in_r           <= VEC_ZERO;
      busy_r             <= 1'b0;
      done_r             <= 1'b0;
      pass_r             <= 1'b0;
      err_count_r        <= ERR_ZERO;
      first_fail_vec_r   <= VEC_ZERO;
      first_fail_valid_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            err_count_r        <= ERR_ZERO;
            first_fail_vec_r   <= VEC_ZERO;
            first_fail_valid_r <= 1'b0;
            pass_r             <= 1'b0;
            dut_in_r           <= VEC_ZERO;
            cnt_r              <= CNT_LOAD;
            busy_r             <= 1'b1;
            state_r            <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (cnt_r == CNT_ZERO) begin
            state_r <= ST_CHECK;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        ST_CHECK: begin
          // Case inequality so an undriven or X gate output scores as a failure.
          if (dut_out !== TRUTH_TABLE[dut_in_r]) begin
            err_count_r <= err_count_r + ERR_ONE;
            if (!first_fail_valid_r) begin
              first_fail_vec_r   <= dut_in_r;
              first_fail_valid_r <= 1'b1;
            end
          end
          if (dut_in_r == VEC_LAST) begin
            state_r <= ST_DONE;
          end else begin
            dut_in_r <= dut_in_r + VEC_ONE;
            cnt_r    <= CNT_LOAD;
            state_r  <= ST_SETTLE;
          end
        end
        ST_DONE: begin
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          pass_r  <= (err_count_r == ERR_ZERO);
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign dut_in           = dut_in_r;
  assign busy             = busy_r;
  assign done             = done_r;
  assign pass             = pass_r;
  assign err_count        = err_count_r;
  assign first_fail_vec   = first_fail_vec_r;
  assign first_fail_valid = first_fail_valid_r;

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Bench: emulated gates (actual truth tables) around a 2-input and a 3-input checker.
module tb_gate_truth_table_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start_a, start_b;
  logic [3:0] act_a;
  logic [7:0] act_b;

  logic [1:0] dut_in_a;
  logic       dut_out_a, busy_a, done_a, pass_a, ffv_a;
  logic [2:0] err_a;
  logic [1:0] ffvec_a;

  logic [2:0] dut_in_b;
  logic       dut_out_b, busy_b, done_b, pass_b, ffv_b;
  logic [3:0] err_b;
  logic [2:0] ffvec_b;

  assign dut_out_a = act_a[dut_in_a];
  assign dut_out_b = act_b[dut_in_b];

  gate_truth_table_checker #(.N_IN(2), .TRUTH_TABLE(4'b0001), .SETTLE_CYCLES(2)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .dut_out(dut_out_a), .dut_in(dut_in_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
    .first_fail_vec(ffvec_a), .first_fail_valid(ffv_a));

  gate_truth_table_checker #(.N_IN(3), .TRUTH_TABLE(8'h01), .SETTLE_CYCLES(2)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .dut_out(dut_out_b), .dut_in(dut_in_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
    .first_fail_vec(ffvec_b), .first_fail_valid(ffv_b));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: count table positions where the gate disagrees with the expected table.
  task automatic model(input logic [7:0] exp_tt, input logic [7:0] act_tt, input int n,
                       output int err, output int first, output bit valid);
    err = 0; first = 0; valid = 1'b0;
    for (int i = 0; i < (1 << n); i++) begin
      if (exp_tt[i] != act_tt[i]) begin
        err++;
        if (!valid) begin first = i; valid = 1'b1; end
      end
    end
  endtask

  // Runs one sweep on the 2-input checker for a fixed 40-cycle window after the start edge.
  task automatic sweep_a(input string nm, input bit extra_starts, input int rst_edge,
                         output int done_edge);
    int c, bad, exp_in;
    bad = 0; done_edge = -1;
    @(negedge clk); start_a = 1'b1;
    @(posedge clk); #1; start_a = 1'b0; c = 0;
    chk({nm, "_cleared"}, {29'd0, err_a, ffv_a, pass_a}, 32'd0);
    while (c < 40) begin
      if (done_a) begin
        if (done_edge < 0) done_edge = c; else bad++;
        if (busy_a !== 1'b0) bad++;
      end
      if (rst_edge < 0 && c <= 11) begin
        exp_in = (c / 3 > 3) ? 3 : c / 3;
        if (dut_in_a !== exp_in[1:0]) bad++;
        if (busy_a !== 1'b1) bad++;
      end
      if (rst_edge >= 0 && c == rst_edge) begin
        chk({nm, "_rst_zero"},
            {22'd0, dut_in_a, busy_a, done_a, pass_a, err_a, ffvec_a, ffv_a}, 32'd0);
        rst_n = 1'b1;
      end
      start_a = (extra_starts && (c == 2 || c == 6)) ? 1'b1 : 1'b0;
      if (rst_edge >= 0 && c == rst_edge - 1) rst_n = 1'b0;
      @(posedge clk); #1; c++;
    end
    chk({nm, "_trace"}, bad, 32'd0);
  endtask

  task automatic sweep_b(input string nm, output int done_edge);
    int c;
    done_edge = -1;
    @(negedge clk); start_b = 1'b1;
    @(posedge clk); #1; start_b = 1'b0; c = 0;
    while (c < 60) begin
      if (done_b && done_edge < 0) done_edge = c;
      @(posedge clk); #1; c++;
    end
  endtask

  typedef struct {
    string      name;
    logic [3:0] act;
    int         exp_err;
    int         exp_first;
    bit         exp_valid;
    bit         exp_pass;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int de, e, f;
    bit v;
    tbl[0] = '{"nor",   4'b0001, 0, 0, 1'b0, 1'b1};
    tbl[1] = '{"tied0", 4'b0000, 1, 0, 1'b1, 1'b0};
    tbl[2] = '{"and",   4'b1000, 2, 0, 1'b1, 1'b0};
    tbl[3] = '{"or",    4'b1110, 4, 0, 1'b1, 1'b0};
    tbl[4] = '{"nand",  4'b0111, 2, 1, 1'b1, 1'b0};
    tbl[5] = '{"xor",   4'b0110, 3, 0, 1'b1, 1'b0};
    tbl[6] = '{"xnor",  4'b1001, 1, 3, 1'b1, 1'b0};

    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; act_a = 4'b0001; act_b = 8'h01;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {22'd0, dut_in_a, busy_a, done_a, pass_a, err_a, ffvec_a, ffv_a}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      act_a = tbl[i].act;
      sweep_a(tbl[i].name, 1'b0, -1, de);
      chk({tbl[i].name, "_done_edge"}, de, 32'd13);
      chk({tbl[i].name, "_err"}, err_a, tbl[i].exp_err);
      chk({tbl[i].name, "_valid"}, ffv_a, tbl[i].exp_valid);
      chk({tbl[i].name, "_pass"}, pass_a, tbl[i].exp_pass);
      if (tbl[i].exp_valid) chk({tbl[i].name, "_first"}, ffvec_a, tbl[i].exp_first);
    end

    // Extra start pulses mid-sweep are ignored.
    act_a = 4'b0001;
    sweep_a("restart_ignored", 1'b1, -1, de);
    chk("restart_done_edge", de, 32'd13);
    chk("restart_pass", pass_a, 32'd1);

    // Reset at edge 5 of a failing sweep aborts it with no done pulse.
    act_a = 4'b0000;
    sweep_a("midreset", 1'b0, 5, de);
    chk("midreset_no_done", de, 32'hFFFF_FFFF);
    act_a = 4'b0001;
    sweep_a("after_reset", 1'b0, -1, de);
    chk("after_reset_done_edge", de, 32'd13);
    chk("after_reset_pass", {err_a, pass_a}, 32'd1);

    for (int r = 0; r < 16; r++) begin
      act_a = 4'($urandom);
      model(8'h01, {4'd0, act_a}, 2, e, f, v);
      sweep_a("rand", 1'b0, -1, de);
      chk("rand_done_edge", de, 32'd13);
      chk("rand_err", err_a, e);
      chk("rand_valid", ffv_a, v);
      chk("rand_pass", pass_a, (e == 0));
      if (v) chk("rand_first", ffvec_a, f);
    end

    act_b = 8'h01;
    sweep_b("nor3", de);
    chk("nor3_done_edge", de, 32'd25);
    chk("nor3_err", err_b, 32'd0);
    chk("nor3_pass", pass_b, 32'd1);
    chk("nor3_valid", ffv_b, 32'd0);
    for (int r = 0; r < 4; r++) begin
      act_b = 8'($urandom);
      model(8'h01, act_b, 3, e, f, v);
      sweep_b("rand3", de);
      chk("rand3_done_edge", de, 32'd25);
      chk("rand3_err", err_b, e);
      chk("rand3_pass", pass_b, (e == 0));
      if (v) chk("rand3_first", ffvec_b, f);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
